// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Retires one multiplier bit per clock, so an N x N multiply takes N cycles.
// o_product holds the last completed result until the next completion or reset.
module multiplier #(
    parameter int unsigned N = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    output logic           o_finished,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic [2*N-1:0] o_product
);

    // Counter must be able to hold the value N itself.
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]     state_q;
    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_d;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] product_q;

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (i_start) begin
                        mcand_q  <= {{N{1'b0}}, i_multiplicand};
                        mplier_q <= i_multiplier;
                        acc_q    <= '0;
                        cnt_q    <= CW'(N);
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    // Last bit: publish the sum including this cycle's partial product.
                    if (cnt_q == CW'(1)) begin
                        product_q <= acc_d;
                        state_q   <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        o_finished = (state_q == StDone);
        o_product  = product_q;
    end

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the shift-and-add multiplier.
// The driver pushes expected product plus accept cycle; the monitor pops on each
// rising o_finished and also checks that o_product holds between completions.
module tb_multiplier;

    localparam int unsigned N = 4;

    typedef struct {
        logic [2*N-1:0] prod;
        int             acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           fin;
    logic [2*N-1:0] prod;

    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    exp_t           exp_q[$];
    logic [2*N-1:0] exp_hold = '0;
    bit             mon_en   = 1'b0;
    bit             prev_fin = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multiplier #(.N(N)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .o_finished     (fin),
        .i_multiplicand (a),
        .i_multiplier   (b),
        .o_product      (prod)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present operands with start high across one edge; that edge accepts.
    task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [2*N-1:0] e, input bit hold);
        exp_t ent;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        ent.prod = e;
        ent.acc  = cyc;
        exp_q.push_back(ent);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clk);
            if (fin) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        exp_q.delete();
        exp_hold = '0;
        rst = 1'b0;
    endtask

    // Monitor: compare on every completion, and check hold otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (fin && !prev_fin) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'(prod), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("product", 32'(prod), 32'(e.prod));
                        check("latency", 32'(cyc - e.acc), N);
                        exp_hold = e.prod;
                    end
                end else begin
                    check("product_hold", 32'(prod), 32'(exp_hold));
                end
                prev_fin = fin;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0] e;
        a     = '0;
        b     = '0;
        // Start high during reset must not be accepted.
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        do_reset(2);
        start = 1'b0;
        @(negedge clk);
        check("reset_product", 32'(prod), 32'd0);
        check("reset_finished", 32'(fin), 32'd0);
        prev_fin = 1'b0;
        mon_en   = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_finished", 32'(fin), 32'd0);
        check("idle_product", 32'(prod), 32'd0);

        // Basic multiply, then hold in DONE.
        do_mul(4'd3, 4'd5, 8'h0F, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        check("done_hold_finished", 32'(fin), 32'd1);

        // Corner operands.
        do_mul(4'd15, 4'd15, 8'hE1, 1'b0); wait_done();
        do_mul(4'd0,  4'd9,  8'h00, 1'b0); wait_done();
        do_mul(4'd9,  4'd0,  8'h00, 1'b0); wait_done();
        do_mul(4'd1,  4'd13, 8'h0D, 1'b0); wait_done();
        do_mul(4'd13, 4'd11, 8'h8F, 1'b0); wait_done();

        // Start pulse and operand change mid-run are ignored.
        do_mul(4'd6, 4'd7, 8'h2A, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        check("no_extra_op", 32'(fin), 32'd1);

        // Back-to-back with start held high.
        do_mul(4'd12, 4'd10, 8'h78, 1'b1);
        a = 4'd7;
        b = 4'd9;
        wait_done();
        @(posedge clk); #1;
        begin
            exp_t ent;
            ent.prod = 8'h3F;
            ent.acc  = cyc;
            exp_q.push_back(ent);
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_finished_gap", 32'(fin), 32'd0);
        wait_done();

        // Reset on the second RUN cycle aborts.
        do_mul(4'd15, 4'd14, 8'hD2, 1'b0);
        @(posedge clk); #1;
        do_reset(1);
        @(negedge clk);
        check("abort_product", 32'(prod), 32'd0);
        check("abort_finished", 32'(fin), 32'd0);
        repeat (N + 2) @(negedge clk);
        check("abort_stays_idle", 32'(fin), 32'd0);
        do_mul(4'd2, 4'd3, 8'h06, 1'b0);
        wait_done();

        // Exhaustive sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                e = 8'(x * y);
                do_mul(x[3:0], y[3:0], e, 1'b0);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned shift-and-add multiplier: N-bit multiplicand × N-bit multiplier → 2N-bit product.
- One multiplier bit is processed per clock cycle, so a multiply takes N cycles.
- A start/finished handshake lets a controlling FSM or datapath issue multiplies and collect results.

Parameters:
- N, 4, operand width in bits (N ≥ 1); product is 2N bits.

Ports:
- i_clock  input  1  system clock; all state changes on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a new multiply; sampled on the rising edge.
- o_finished  output  1  high while a completed result is held on o_product.
- i_multiplicand  input  N  unsigned multiplicand; captured when the start is accepted.
- i_multiplier  input  N  unsigned multiplier; captured when the start is accepted.
- o_product  output  2N  registered unsigned product of the last completed operation.

Behaviour:
- One clock domain; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state IDLE, o_finished 0, o_product 0, internal registers 0.
- States and transitions:
  - IDLE: o_finished 0. i_start=1 accepts a start → RUN.
  - RUN: o_finished 0. i_start is ignored. After N cycles → DONE.
  - DONE: o_finished 1. i_start=1 accepts a new start → RUN. Otherwise stays in DONE, holding o_product.
- Start acceptance (edge E0, state IDLE or DONE, i_start=1):
  - latch i_multiplicand into a 2N-bit shift-left register, zero-extended;
  - latch i_multiplier into an N-bit shift-right register;
  - clear the 2N-bit accumulator;
  - load the iteration counter with N;
  - o_finished goes 0 after E0.
- Each RUN edge:
  - if multiplier register bit 0 = 1, accumulator += multiplicand register (mod 2^2N; overflow is impossible);
  - multiplicand register <<= 1; multiplier register >>= 1; counter −= 1.
- On the RUN edge where the counter reaches 0 (edge E0+N):
  - o_product ← final accumulator value;
  - state → DONE, so o_finished is 1 after edge E0+N.
- Latency: exactly N clock edges from start acceptance to o_finished=1.
- Throughput: a start held high in DONE begins the next multiply immediately. Back-to-back operations take N+1 cycles each.
- o_product changes only at completion or reset. It keeps the previous result through RUN (not intermediate sums).
- Operand inputs may change freely after E0 without affecting the running operation.
- i_start held high continuously restarts immediately after every completion.
- i_reset asserted mid-RUN aborts the operation: next state IDLE, o_product 0, o_finished 0.
- i_reset and i_start high together: reset wins; no start is accepted.
- All arithmetic is unsigned. The result equals i_multiplicand × i_multiplier exactly for all 2^(2N) operand pairs.

Test Plan:
- Reset then idle: assert i_reset for 2 cycles → o_product=0x00, o_finished=0; both stay there with i_start=0.
- Basic multiply (N=4): start with 3×5 → o_finished rises exactly 4 edges after the accepting edge; o_product=15 (0x0F); finished stays high and the value is held while i_start=0.
- Corner operands: 15×15 → 225 (0xE1); 0×9 → 0; 9×0 → 0; 1×13 → 13; 13×11 → 143 (0x8F).
- Start ignored during RUN plus operand change: start 6×7, then pulse i_start and change operands to 2×2 mid-run → completes at the original latency with 42 (0x2A), and no extra operation follows.
- Back-to-back: i_start held high with 12×10, then 7×9 → results 120 (0x78) then 63 (0x3F). o_finished is high for one cycle between the two operations; o_product holds 120 until the second completion.
- Reset mid-operation: start 15×14, assert i_reset on the 2nd RUN cycle → o_product=0 and o_finished=0 next cycle. A following 2×3 start yields 6.
- Exhaustive sweep (N=4): all 256 operand pairs → o_product = a×b at every completion.
